mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: an MDU instruction is in E stage this cycle.
REQ-006 SHALL have port op, input, 4 bits: MDU opcode (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
REQ-007 SHALL have ports rs_val and rt_val, inputs, 32 bits each: operands A and B.
REQ-008 SHALL have port cancel, input, 1 bit: E-stage exception or flush; suppresses this cycle's start.
REQ-009 SHALL have port md_in_d, input, 1 bit: an MDU-class instruction is in D stage.
REQ-010 SHALL have port busy, output, 1 bit: a multiply or divide is in flight.
REQ-011 SHALL have port stall, output, 1 bit: pipeline freeze request for the D stage.
REQ-012 SHALL have ports hi and lo, outputs, 32 bits each: architectural HI and LO.
REQ-013 SHALL have port rdata, output, 32 bits: hi when op=MFHI, lo when op=MFLO, otherwise 0.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and RUN; "accept" means start=1, cancel=0 and state=IDLE.
REQ-015 SHALL, on accept of MULT/MULTU/DIV/DIVU, latch the operands, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN at the next edge.
REQ-016 SHALL hold busy=1 in every RUN cycle, so busy is high for exactly N consecutive cycles beginning the cycle after accept.
REQ-017 SHALL decrement the counter once per RUN cycle; at the edge where the counter goes 1->0 it SHALL write HI/LO and return to IDLE, so new values are visible in the first cycle busy=0.
REQ-018 SHALL compute MULT as the signed 64-bit product and MULTU as the unsigned 64-bit product, with {hi,lo} = product.
REQ-019 SHALL compute DIV/DIVU with lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-020 SHALL handle divide by zero as lo = 32'hFFFF_FFFF, hi = rs_val (latched).
REQ-021 SHALL handle signed overflow 0x8000_0000 / -1 as lo = 0x8000_0000, hi = 0.
REQ-022 SHALL, on accept of MTHI or MTLO, write rs_val to hi or lo at the next edge, with no RUN state and no busy.
REQ-023 SHALL ignore start while in RUN; upstream prevents this via stall.
REQ-024 SHALL drive stall = md_in_d & (busy | (start & ~cancel & op in {MULT, MULTU, DIV, DIVU})), purely combinational.
REQ-025 SHALL ignore cancel during RUN; an in-flight operation always completes.
REQ-026 SHALL, when accept and the final RUN edge fall in the same cycle, complete the old operation first and accept the new one in IDLE next cycle; this is unreachable when stall is respected.
REQ-027 SHALL produce no result and no state change for op=NONE or for unknown opcodes.

Reset
REQ-028 SHALL, when reset=1 at an edge, set state=IDLE, counter=0, hi=0, lo=0, and clear the latched operands.
REQ-029 SHALL, after reset, hold busy=0 and stall=0 until the next accept.
REQ-030 SHALL, if reset is asserted during RUN, abort the operation without writing HI/LO; reset wins over all inputs.

Configuration
REQ-031 SHALL, when MDU_PERF_CNT_EN is defined, add output perf_stall_cnt, 32 bits: increments every cycle stall=1, wraps at 2^32, and clears on reset.
REQ-032 SHALL, when MDU_PERF_CNT_EN is not defined, omit the port and the counter logic entirely.

Structure
REQ-033 SHALL place in shared package mdu_pkg: the op encodings, the FSM state encoding, and the default cycle-count constants.
REQ-034 SHALL place the 64-bit result computation (mult, div, and special cases) in combinational sub-module mdu_calc; mdu_ctrl holds the FSM, counter, operand latches, HI/LO and stall logic.

Verification
REQ-035 SHALL cover MULT with rs=0xFFFF_FFFE and rt=3: busy high for cycles 1-5; at cycle 6 hi=0xFFFF_FFFF and lo=0xFFFF_FFFA.
REQ-036 SHALL cover DIVU with rs=100 and rt=7: busy high for 10 cycles, then lo=14 and hi=2; also DIV with rs=-7 and rt=2: lo=-3 and hi=-1.
REQ-037 SHALL cover the DIV special cases: rs=5, rt=0 gives lo=0xFFFF_FFFF and hi=5; rs=0x8000_0000, rt=-1 gives lo=0x8000_0000 and hi=0.
REQ-038 SHALL cover stall: md_in_d=1 throughout a MULT gives stall=1 from the accept cycle through the last busy cycle, then 0; MFLO after that returns the new lo.
REQ-039 SHALL cover cancel: MULT with cancel=1 keeps busy=0 and HI/LO unchanged; cancel=1 during RUN still completes the operation.
REQ-040 SHALL cover reset: reset at RUN cycle 3 of a DIV gives busy=0 and hi=lo=0 the next cycle; MTHI with rs=0x1234 then gives hi=0x1234 one cycle later.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode and FSM encodings
// plus default busy-cycle counts.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Multi-cycle ops are the only ones that occupy the RUN state.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for MULT/MULTU/DIV/DIVU, including the
// MIPS-style divide-by-zero and signed-overflow results.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        div_zero;
  logic        div_ovf;

  // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign quo_s = $signed(a) / $signed(b);
  assign rem_s = $signed(a) % $signed(b);
  assign quo_u = a / b;
  assign rem_u = a % b;

  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op_t'(op))
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_zero) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a;
        end else if (div_ovf) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = quo_s;
          res_hi = rem_s;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a;
        end else begin
          res_lo = quo_u;
          res_hi = rem_u;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/RUN FSM, busy counter, operand latches, HI/LO and
// D-stage stall. Optional stall counter enabled by defining MDU_PERF_CNT_EN.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
`ifdef MDU_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  state_t      state;
  state_t      state_n;
  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        accept;
  logic        long_op;
  logic        finish;

  assign accept  = start & ~cancel & (state == ST_IDLE);
  assign long_op = is_long_op(op);
  // A count of 1 marks the last RUN cycle; <= guards a zero cycle parameter.
  assign finish  = (state == ST_RUN) && (cnt <= 32'd1);
  assign busy    = (state == ST_RUN);
  assign stall   = md_in_d & (busy | (start & ~cancel & long_op));

  mdu_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .res_hi (calc_hi),
    .res_lo (calc_lo)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept && long_op) begin
          state_n = ST_RUN;
          cnt_n   = is_mult_op(op) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
        end
      end
      ST_RUN: begin
        if (finish) begin
          state_n = ST_IDLE;
          cnt_n   = 32'd0;
        end else begin
          cnt_n   = cnt - 32'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 32'd0;
      end
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (op_t'(op))
      OP_MFHI: rdata = hi;
      OP_MFLO: rdata = lo;
      default: rdata = 32'd0;
    endcase
  end

  // Result writeback and MTHI/MTLO are mutually exclusive: one needs RUN, the other IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 32'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept && long_op) begin
        op_q <= op;
        a_q  <= rs_val;
        b_q  <= rt_val;
      end
      if (finish) begin
        hi <= calc_hi;
        lo <= calc_lo;
      end else if (accept && (op == OP_MTHI)) begin
        hi <= rs_val;
      end else if (accept && (op == OP_MTLO)) begin
        lo <= rs_val;
      end
    end
  end

`ifdef MDU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
    end else if (stall) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
